streetlight_td_scheduler: RTL and testbench

Time-of-day scheduler for the ten-lamp streetlight brightness stage. It keeps an hour and day-of-week calendar from a periodic tick and produces the 2-bit brightness code `td` and the 3-bit `day` code that drive the lamp-level decoder. It adds a debounced ambient-darkness override and a retriggerable traffic boost. Sits between the board timebase/sensors and the lamp brightness decoder.

---
 rtl/streetlight_td_scheduler.sv | 164 ++++++++++++++++
 tb/tb_streetlight_td_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/streetlight_td_scheduler.sv
// Time-of-day scheduler for the streetlight brightness stage.
// Keeps an hour/day-of-week calendar from a tick strobe and produces the
// brightness code (td) and the lit-day code (day) for the lamp decoder, with
// a debounced ambient-darkness override and a retriggerable traffic boost.
module streetlight_td_scheduler #(
  parameter int unsigned TICKS_PER_HOUR = 3600,
  parameter int unsigned DUSK_HOUR      = 18,
  parameter int unsigned NIGHT_HOUR     = 22,
  parameter int unsigned LATE_HOUR      = 2,
  parameter int unsigned PREDAWN_HOUR   = 5,
  parameter int unsigned DAWN_HOUR      = 6,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned BOOST_TICKS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ambient_dark,
  input  logic       traffic,
  input  logic       load_en,
  input  logic [4:0] load_hour,
  input  logic [2:0] load_dow,
  output logic [1:0] td,
  output logic [2:0] day,
  output logic [4:0] hour,
  output logic [2:0] dow,
  output logic       lamps_on
);

  localparam int unsigned TCW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned BSW = $clog2(BOOST_TICKS + 1);

  localparam logic [2:0] S_DAY      = 3'd0;
  localparam logic [2:0] S_EVENING  = 3'd1;
  localparam logic [2:0] S_NIGHT    = 3'd2;
  localparam logic [2:0] S_LATE     = 3'd3;
  localparam logic [2:0] S_PREDAWN  = 3'd4;
  localparam logic [2:0] S_OVERRIDE = 3'd5;

  logic [TCW-1:0] tick_cnt;
  logic [DBW-1:0] debounce_cnt;
  logic [BSW-1:0] boost_cnt;
  logic           amb_meta;
  logic           amb_sync;
  logic           accepted_dark;
  logic [2:0]     band;
  logic [2:0]     band_next;
  logic [1:0]     td_next;
  logic [2:0]     day_next;
  logic           lamps_next;
  logic           load_ok;
  logic           enter_day;

  assign load_ok   = load_en && (load_hour <= 5'd23) && (load_dow <= 3'd6);
  assign enter_day = (band_next == S_DAY) && (band != S_DAY);

  // Calendar: tick prescaler, hour and day-of-week; a valid load wins over a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      hour     <= '0;
      dow      <= '0;
    end else if (load_ok) begin
      tick_cnt <= '0;
      hour     <= load_hour;
      dow      <= load_dow;
    end else if (tick) begin
      if (tick_cnt == TCW'(TICKS_PER_HOUR - 1)) begin
        tick_cnt <= '0;
        if (hour == 5'd23) begin
          hour <= '0;
          dow  <= (dow == 3'd6) ? 3'd0 : dow + 3'd1;
        end else begin
          hour <= hour + 5'd1;
        end
      end else begin
        tick_cnt <= tick_cnt + TCW'(1);
      end
    end
  end

  // Ambient sensor: two-flop synchronizer, then tick-based debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      amb_meta      <= 1'b0;
      amb_sync      <= 1'b0;
      accepted_dark <= 1'b0;
      debounce_cnt  <= '0;
    end else begin
      amb_meta <= ambient_dark;
      amb_sync <= amb_meta;
      if (amb_sync == accepted_dark) begin
        debounce_cnt <= '0;
      end else if (tick) begin
        if (debounce_cnt == DBW'(DEBOUNCE_TICKS - 1)) begin
          accepted_dark <= ~accepted_dark;
          debounce_cnt  <= '0;
        end else begin
          debounce_cnt <= debounce_cnt + DBW'(1);
        end
      end
    end
  end

  // Traffic boost: reload on motion while lit, count down on ticks, drop on entering unlit day
  always_ff @(posedge clk) begin
    if (rst) begin
      boost_cnt <= '0;
    end else if (enter_day) begin
      boost_cnt <= '0;
    end else if (traffic && lamps_on) begin
      boost_cnt <= BSW'(BOOST_TICKS);
    end else if (tick && (boost_cnt != '0)) begin
      boost_cnt <= boost_cnt - BSW'(1);
    end
  end

  // Band state register and registered lamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      band     <= S_DAY;
      td       <= 2'b00;
      day      <= 3'b111;
      lamps_on <= 1'b0;
    end else begin
      band     <= band_next;
      td       <= td_next;
      day      <= day_next;
      lamps_on <= lamps_next;
    end
  end

  // Next band from the hour register, and the outputs that band implies
  always_comb begin
    band_next  = S_NIGHT;
    td_next    = 2'b01;
    day_next   = dow;
    lamps_next = 1'b1;
    if ((hour >= 5'(DAWN_HOUR)) && (hour < 5'(DUSK_HOUR))) begin
      band_next = accepted_dark ? S_OVERRIDE : S_DAY;
    end else if ((hour >= 5'(DUSK_HOUR)) && (hour < 5'(NIGHT_HOUR))) begin
      band_next = S_EVENING;
    end else if ((hour >= 5'(LATE_HOUR)) && (hour < 5'(PREDAWN_HOUR))) begin
      band_next = S_LATE;
    end else if ((hour >= 5'(PREDAWN_HOUR)) && (hour < 5'(DAWN_HOUR))) begin
      band_next = S_PREDAWN;
    end
    case (band_next)
      S_DAY: begin
        td_next    = 2'b00;
        day_next   = 3'b111;
        lamps_next = 1'b0;
      end
      S_EVENING, S_OVERRIDE: td_next = 2'b10;
      S_LATE:                td_next = 2'b00;
      default:               td_next = 2'b01;
    endcase
    if (lamps_next && (boost_cnt != '0)) begin
      td_next = 2'b11;
    end
  end

endmodule

// File: tb/tb_streetlight_td_scheduler.sv
// Scoreboard bench for streetlight_td_scheduler (TICKS_PER_HOUR = 4).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_streetlight_td_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ambient_dark = 1'b0;
  logic       traffic = 1'b0;
  logic       load_en = 1'b0;
  logic [4:0] load_hour = '0;
  logic [2:0] load_dow = '0;
  logic [1:0] td;
  logic [2:0] day;
  logic [4:0] hour;
  logic [2:0] dow;
  logic       lamps_on;

  localparam logic [4:0] M_TD  = 5'b00001;
  localparam logic [4:0] M_DAY = 5'b00010;
  localparam logic [4:0] M_HR  = 5'b00100;
  localparam logic [4:0] M_DOW = 5'b01000;
  localparam logic [4:0] M_LMP = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct {
    string      name;
    logic [4:0] mask;
    logic [1:0] td;
    logic [2:0] day;
    logic [4:0] hour;
    logic [2:0] dow;
    logic       lamps;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  streetlight_td_scheduler #(.TICKS_PER_HOUR(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ambient_dark(ambient_dark),
    .traffic(traffic), .load_en(load_en), .load_hour(load_hour),
    .load_dow(load_dow), .td(td), .day(day), .hour(hour), .dow(dow),
    .lamps_on(lamps_on)
  );

  always #5 clk = ~clk;

  // Field compare used by the monitor
  task automatic chk(input string nm, input string fld, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: compare every pending expectation against the outputs at negedge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) chk(e.name, "td",       int'(td),       int'(e.td));
      if (e.mask[1]) chk(e.name, "day",      int'(day),      int'(e.day));
      if (e.mask[2]) chk(e.name, "hour",     int'(hour),     int'(e.hour));
      if (e.mask[3]) chk(e.name, "dow",      int'(dow),      int'(e.dow));
      if (e.mask[4]) chk(e.name, "lamps_on", int'(lamps_on), int'(e.lamps));
    end
  end

  task automatic expect_out(input string nm, input logic [4:0] m, input logic [1:0] t,
                            input logic [2:0] d, input logic [4:0] h, input logic [2:0] w,
                            input logic l);
    exp_t e;
    e.name = nm; e.mask = m; e.td = t; e.day = d; e.hour = h; e.dow = w; e.lamps = l;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each tick is a one-cycle strobe followed by an idle cycle
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic load(input logic [4:0] h, input logic [2:0] w);
    load_hour = h;
    load_dow  = w;
    load_en   = 1'b1;
    cyc();
    load_en = 1'b0;
    cyc();
  endtask

  task automatic pulse_traffic();
    traffic = 1'b1;
    cyc();
    traffic = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and calendar advance to dusk
    rst = 1'b1;
    cyc(); cyc();
    expect_out("reset", M_ALL, 2'b00, 3'b111, 5'd0, 3'd0, 1'b0);
    rst = 1'b0;
    cyc();
    expect_out("rel_night", M_ALL, 2'b01, 3'd0, 5'd0, 3'd0, 1'b1);
    ticks(71);
    expect_out("h17_off", M_ALL, 2'b00, 3'b111, 5'd17, 3'd0, 1'b0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    expect_out("h18_edge", M_ALL, 2'b00, 3'b111, 5'd18, 3'd0, 1'b0);
    cyc();
    expect_out("h18_lit", M_ALL, 2'b10, 3'd0, 5'd18, 3'd0, 1'b1);

    // Load and day-of-week wrap
    load(5'd23, 3'd6);
    expect_out("load23", M_ALL, 2'b01, 3'd6, 5'd23, 3'd6, 1'b1);
    ticks(4);
    expect_out("wrap", M_ALL, 2'b01, 3'd0, 5'd0, 3'd0, 1'b1);
    ticks(8);
    expect_out("h2_late", M_ALL, 2'b00, 3'd0, 5'd2, 3'd0, 1'b1);

    // Traffic boost, expiry and retrigger
    pulse_traffic();
    expect_out("boost_on", M_TD, 2'b11, 3'd0, 5'd0, 3'd0, 1'b0);
    ticks(7);
    expect_out("boost_7", M_TD | M_HR, 2'b11, 3'd0, 5'd3, 3'd0, 1'b0);
    ticks(1);
    expect_out("boost_end", M_ALL, 2'b00, 3'd0, 5'd4, 3'd0, 1'b1);
    load(5'd18, 3'd2);
    expect_out("eve", M_ALL, 2'b10, 3'd2, 5'd18, 3'd2, 1'b1);
    pulse_traffic();
    ticks(4);
    expect_out("boost_4", M_TD, 2'b11, 3'd0, 5'd0, 3'd0, 1'b0);
    tick = 1'b1; traffic = 1'b1;
    cyc();
    tick = 1'b0; traffic = 1'b0;
    cyc();
    expect_out("retrig", M_TD, 2'b11, 3'd0, 5'd0, 3'd0, 1'b0);
    ticks(7);
    expect_out("retrig_7", M_TD | M_HR, 2'b11, 3'd0, 5'd21, 3'd0, 1'b0);
    ticks(1);
    expect_out("retrig_end", M_ALL, 2'b10, 3'd2, 5'd21, 3'd2, 1'b1);
    load(5'd10, 3'd3);
    expect_out("day10", M_ALL, 2'b00, 3'b111, 5'd10, 3'd3, 1'b0);
    pulse_traffic();
    expect_out("traffic_day", M_ALL, 2'b00, 3'b111, 5'd10, 3'd3, 1'b0);

    // Ambient debounce and override
    ambient_dark = 1'b1;
    cyc(); cyc();
    ticks(3);
    expect_out("amb3", M_ALL, 2'b00, 3'b111, 5'd10, 3'd3, 1'b0);
    ambient_dark = 1'b0;
    cyc(); cyc(); cyc();
    ambient_dark = 1'b1;
    cyc(); cyc();
    ticks(3);
    expect_out("amb_cleared", M_ALL, 2'b00, 3'b111, 5'd11, 3'd3, 1'b0);
    ticks(1);
    expect_out("override", M_ALL, 2'b10, 3'd3, 5'd11, 3'd3, 1'b1);
    ambient_dark = 1'b0;
    cyc(); cyc();
    ticks(4);
    expect_out("override_off", M_ALL, 2'b00, 3'b111, 5'd12, 3'd3, 1'b0);

    // Invalid loads and load/tick collision
    load(5'd24, 3'd1);
    expect_out("bad_hour", M_HR | M_DOW, 2'b00, 3'd0, 5'd12, 3'd3, 1'b0);
    load(5'd5, 3'd7);
    expect_out("bad_dow", M_HR | M_DOW, 2'b00, 3'd0, 5'd12, 3'd3, 1'b0);
    ticks(1);
    expect_out("cnt_kept", M_HR, 2'b00, 3'd0, 5'd13, 3'd0, 1'b0);
    load_hour = 5'd20; load_dow = 3'd4; load_en = 1'b1; tick = 1'b1;
    cyc();
    load_en = 1'b0; tick = 1'b0;
    cyc();
    expect_out("load_tick", M_ALL, 2'b10, 3'd4, 5'd20, 3'd4, 1'b1);
    ticks(3);
    expect_out("cnt_cleared", M_HR, 2'b00, 3'd0, 5'd20, 3'd0, 1'b0);
    ticks(1);
    expect_out("cnt_wrap", M_HR, 2'b00, 3'd0, 5'd21, 3'd0, 1'b0);

    // Reset during an active boost
    load(5'd20, 3'd5);
    pulse_traffic();
    expect_out("boost20", M_TD, 2'b11, 3'd0, 5'd0, 3'd0, 1'b0);
    rst = 1'b1;
    cyc();
    expect_out("rst_boost", M_ALL, 2'b00, 3'b111, 5'd0, 3'd0, 1'b0);
    rst = 1'b0;
    cyc();
    expect_out("post_rst", M_ALL, 2'b01, 3'd0, 5'd0, 3'd0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
